// File: rtl/hamming_pkg.sv
// Shared SECDED Hamming helpers: parity-width calculation, position map and status encoding.
// Used by both the encoder and the decoder.
package hamming_pkg;

  typedef enum logic [1:0] {
    ECC_CLEAN = 2'd0,
    ECC_SEC   = 2'd1,
    ECC_DED   = 2'd2
  } ecc_status_t;

  // Smallest m with 2**m >= m + k + 1
  function automatic int unsigned calc_m(input int unsigned k);
    int unsigned m;
    m = 1;
    while ((32'd1 << m) < (m + k + 1)) m++;
    return m;
  endfunction

  function automatic bit is_pow2(input int unsigned x);
    return (x != 0) && ((x & (x - 1)) == 0);
  endfunction

  // Codeword position (1-based) holding data bit idx; data fills non-power-of-two slots in order
  function automatic int unsigned data_pos(input int unsigned idx);
    int unsigned cnt;
    int unsigned res;
    cnt = 0;
    res = 0;
    for (int unsigned p = 1; p <= idx + 40; p++) begin
      if (!is_pow2(p)) begin
        if (cnt == idx) res = p;
        cnt++;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational SECDED syndrome: XOR of indices of set positions 1..n plus overall parity.
module hamming_syndrome
  import hamming_pkg::*;
#(
  parameter int unsigned K      = 8,
  parameter bit          P0_LSB = 1'b1,
  localparam int unsigned M     = calc_m(K),
  localparam int unsigned N     = M + K + 1
) (
  input  logic [N-1:0] cw,
  output logic [M-1:0] syn,
  output logic         par
);

  localparam int unsigned NPOS = M + K;
  localparam int unsigned OFS  = P0_LSB ? 0 : 1;

  always_comb begin
    syn = '0;
    for (int unsigned p = 1; p <= NPOS; p++) begin
      if (cw[p - OFS]) syn = syn ^ M'(p);
    end
    par = ^cw;
  end

endmodule

// File: rtl/hamming_secded_dec.sv
// Pipelined SECDED Hamming decoder with valid/ready on both sides.
// Optional error counters are built when ECC_ERR_CNT_EN is defined.
module hamming_secded_dec
  import hamming_pkg::*;
#(
  parameter int unsigned K      = 8,
  parameter bit          P0_LSB = 1'b1,
  parameter bit          PIPE   = 1'b1,
`ifdef ECC_ERR_CNT_EN
  parameter int unsigned CNT_W  = 16,
`endif
  localparam int unsigned M     = calc_m(K),
  localparam int unsigned N     = M + K + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [N-1:0]     s_cw_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [K-1:0]     m_d_o,
  output logic             m_sec_o,
  output logic             m_ded_o,
  output logic [M-1:0]     m_syn_o
`ifdef ECC_ERR_CNT_EN
  ,
  input  logic             cnt_clr_i,
  output logic [CNT_W-1:0] sec_cnt_o,
  output logic [CNT_W-1:0] ded_cnt_o
`endif
);

  localparam int unsigned NPOS = M + K;
  localparam int unsigned OFS  = P0_LSB ? 0 : 1;

  logic [M-1:0] in_syn;
  logic         in_par;
  logic [K-1:0] in_raw;

  logic         c_valid;
  logic [K-1:0] c_raw;
  logic [M-1:0] c_syn;
  logic         c_par;
  logic [K-1:0] c_d;
  logic         c_flip;
  ecc_status_t  c_status;

  logic         out_load;

  assign out_load = !m_valid_o || m_ready_i;

  hamming_syndrome #(
    .K      (K),
    .P0_LSB (P0_LSB)
  ) u_syndrome (
    .cw  (s_cw_i),
    .syn (in_syn),
    .par (in_par)
  );

  // Raw (uncorrected) data bits pulled out of the codeword
  always_comb begin
    in_raw = '0;
    for (int unsigned k = 0; k < K; k++) begin
      in_raw[k] = s_cw_i[data_pos(k) - OFS];
    end
  end

  generate
    if (PIPE) begin : g_pipe
      logic         s1_valid;
      logic [K-1:0] s1_raw;
      logic [M-1:0] s1_syn;
      logic         s1_par;
      logic         s1_load;

      assign s1_load = !s1_valid || out_load;

      // Syndrome stage: captures raw data with its syndrome and parity
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          s1_valid <= 1'b0;
          s1_raw   <= '0;
          s1_syn   <= '0;
          s1_par   <= 1'b0;
        end else if (s1_load) begin
          s1_valid <= s_valid_i;
          if (s_valid_i) begin
            s1_raw <= in_raw;
            s1_syn <= in_syn;
            s1_par <= in_par;
          end
        end
      end

      assign s_ready_o = s1_load;
      assign c_valid   = s1_valid;
      assign c_raw     = s1_raw;
      assign c_syn     = s1_syn;
      assign c_par     = s1_par;
    end else begin : g_flat
      assign s_ready_o = out_load;
      assign c_valid   = s_valid_i;
      assign c_raw     = in_raw;
      assign c_syn     = in_syn;
      assign c_par     = in_par;
    end
  endgenerate

  // Classify the error and flip the addressed data bit for a correctable single error
  always_comb begin
    c_status = ECC_CLEAN;
    c_flip   = 1'b0;
    if (c_syn == '0) begin
      c_status = c_par ? ECC_SEC : ECC_CLEAN;
    end else if (!c_par) begin
      c_status = ECC_DED;
    end else if (c_syn > M'(NPOS)) begin
      c_status = ECC_DED;
    end else begin
      c_status = ECC_SEC;
      c_flip   = 1'b1;
    end

    c_d = c_raw;
    for (int unsigned k = 0; k < K; k++) begin
      if (c_flip && (c_syn == M'(data_pos(k)))) c_d[k] = ~c_raw[k];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_valid_o <= 1'b0;
      m_d_o     <= '0;
      m_sec_o   <= 1'b0;
      m_ded_o   <= 1'b0;
      m_syn_o   <= '0;
    end else if (out_load) begin
      m_valid_o <= c_valid;
      if (c_valid) begin
        m_d_o   <= c_d;
        m_sec_o <= (c_status == ECC_SEC);
        m_ded_o <= (c_status == ECC_DED);
        m_syn_o <= c_syn;
      end
    end
  end

`ifdef ECC_ERR_CNT_EN
  logic out_fire;

  assign out_fire = m_valid_o && m_ready_i;

  // Saturating event counters; clear takes priority over a same-cycle increment
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sec_cnt_o <= '0;
      ded_cnt_o <= '0;
    end else if (cnt_clr_i) begin
      sec_cnt_o <= '0;
      ded_cnt_o <= '0;
    end else begin
      if (out_fire && m_sec_o && (sec_cnt_o != '1)) sec_cnt_o <= sec_cnt_o + CNT_W'(1);
      if (out_fire && m_ded_o && (ded_cnt_o != '1)) ded_cnt_o <= ded_cnt_o + CNT_W'(1);
    end
  end
`endif

endmodule
